// File: rtl/ant_nav_supervisor.sv
// ant_nav_supervisor: arbitrates the ant move bus between the wall follower,
// a fixed post-collision recovery routine, an escape halt and a step watchdog.
module ant_nav_supervisor #(
   parameter logic [1:0] MV_HALT  = 2'b00,
   parameter logic [1:0] MV_RIGHT = 2'b01,
   parameter logic [1:0] MV_LEFT  = 2'b10,
   parameter logic [1:0] MV_FWD   = 2'b11,
   parameter int PH_WIDTH      = 2,
   parameter int RECOVER_TURNS = 2,
   parameter int PH_PERIOD     = 4,
   parameter int STEP_LIMIT    = 1000,
   parameter int STEP_W        = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic [1:0]          req_move,
   output logic                req_ack,
   input  logic                hit,
   input  logic                escape,
   input  logic [PH_WIDTH-1:0] ph_detected,
   output logic [PH_WIDTH-1:0] ph_drop,
   output logic [1:0]          move,
   output logic [STEP_W-1:0]   step_cnt,
   output logic [2:0]          state_o,
   output logic                done,
   output logic                timeout
);
   localparam int RW = RECOVER_TURNS > 1 ? $clog2(RECOVER_TURNS) : 1;
   localparam int FW = PH_PERIOD > 1 ? $clog2(PH_PERIOD) : 1;
   localparam logic [PH_WIDTH-1:0] PH_ONE = 1;
   typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, RECOVER = 3'd2, DONE = 3'd3, TIMEOUT = 3'd4} state_t;
   state_t state, state_n;
   logic [1:0] move_n;
   logic ack_n;
   logic [RW-1:0] rec_cnt, rec_n;
   logic [FW-1:0] fwd_cnt;
   logic is_fwd, ph_seen, fwd_wrap;
   assign state_o = state;
   assign is_fwd = move_n == MV_FWD;
   assign ph_seen = ph_detected != '0;
   assign fwd_wrap = fwd_cnt == FW'(PH_PERIOD - 1);
   always_comb begin
      state_n = state;
      move_n = MV_HALT;
      ack_n = 1'b0;
      rec_n = rec_cnt;
      case (state)
         IDLE: state_n = RUN;
         RUN:
            if (escape) state_n = DONE;
            else if (hit) begin
               state_n = RECOVER;
               move_n = MV_RIGHT;
               rec_n = RW'(RECOVER_TURNS - 1);
            end else if (step_cnt == STEP_W'(STEP_LIMIT)) state_n = TIMEOUT;
            else if (req_valid) begin
               move_n = req_move;
               ack_n = 1'b1;
            end
         RECOVER:
            if (escape) state_n = DONE;
            else if (hit) begin
               move_n = MV_RIGHT;
               rec_n = RW'(RECOVER_TURNS - 1);
            end else if (rec_cnt != '0) begin
               move_n = MV_RIGHT;
               rec_n = rec_cnt - 1'b1;
            end else begin
               move_n = MV_FWD;
               state_n = RUN;
            end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         move <= MV_HALT;
         req_ack <= 1'b0;
         ph_drop <= '0;
         step_cnt <= '0;
         done <= 1'b0;
         timeout <= 1'b0;
         rec_cnt <= '0;
         fwd_cnt <= '0;
      end else begin
         state <= state_n;
         move <= move_n;
         req_ack <= ack_n;
         rec_cnt <= rec_n;
         done <= done | (state_n == DONE);
         timeout <= timeout | (state_n == TIMEOUT);
         if (move_n != MV_HALT && step_cnt != '1) step_cnt <= step_cnt + 1'b1;
         // a sensed trail resets the spacing so drops stay PH_PERIOD forwards from any trail
         ph_drop <= (is_fwd && !ph_seen && fwd_wrap) ? PH_ONE : '0;
         if (is_fwd) fwd_cnt <= (ph_seen || fwd_wrap) ? '0 : fwd_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_ant_nav_supervisor.sv
// tb_ant_nav_supervisor: directed and random stimulus against a queue-based
// reference model; a separate monitor compares every registered output cycle.
module tb_ant_nav_supervisor;
   localparam int RT = 2, PP = 4, LIM = 12, SW = 4;
   localparam int SMAX = (1 << SW) - 1;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid = 1'b0, hit = 1'b0, escape = 1'b0, req_ack, done, timeout;
   logic [1:0] req_move = 2'b00, move, ph_detected = 2'b00, ph_drop;
   logic [SW-1:0] step_cnt;
   logic [2:0] state_o;
   typedef struct packed {
      logic [2:0] st;
      logic dn, to, ack;
      logic [1:0] mv, ph;
      logic [SW-1:0] sc;
   } obs_t;
   obs_t exp_q[$];
   int n_cmp = 0, n_err = 0;
   int m_state, m_step, m_since;
   int plan[$];

   ant_nav_supervisor #(.RECOVER_TURNS(RT), .PH_PERIOD(PP), .STEP_LIMIT(LIM), .STEP_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_move(req_move), .req_ack(req_ack),
      .hit(hit), .escape(escape), .ph_detected(ph_detected), .ph_drop(ph_drop), .move(move),
      .step_cnt(step_cnt), .state_o(state_o), .done(done), .timeout(timeout));

   always #5 clk = ~clk;

   function automatic obs_t mk(int st, int mv, int ack, int ph);
      obs_t o;
      o.st = 3'(st);
      o.dn = m_state == 3;
      o.to = m_state == 4;
      o.ack = 1'(ack);
      o.mv = 2'(mv);
      o.ph = 2'(ph);
      o.sc = SW'(m_step);
      return o;
   endfunction

   task automatic fresh_plan();
      plan.delete();
      for (int i = 0; i < RT; i++) plan.push_back(1);
      plan.push_back(3);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      m_state = 0; m_step = 0; m_since = 0;
      plan.delete();
      exp_q.push_back(mk(0, 0, 0, 0));
   endtask

   task automatic drive(input logic rv, input logic [1:0] rm, input logic h, input logic e, input logic [1:0] ph);
      int mv, ack, drop;
      @(negedge clk);
      rst_n = 1'b1; req_valid = rv; req_move = rm; hit = h; escape = e; ph_detected = ph;
      mv = 0; ack = 0; drop = 0;
      case (m_state)
         0: m_state = 1;
         1: if (e) m_state = 3;
            else if (h) begin fresh_plan(); mv = plan.pop_front(); m_state = 2; end
            else if (m_step == LIM) m_state = 4;
            else if (rv) begin mv = int'(rm); ack = 1; end
         2: if (e) m_state = 3;
            else begin
               if (h) fresh_plan();
               mv = plan.pop_front();
               if (plan.size() == 0) m_state = 1;
            end
         default: ;
      endcase
      if (mv != 0 && m_step < SMAX) m_step++;
      if (mv == 3) begin
         if (ph != 0) m_since = 0;
         else begin
            m_since++;
            if (m_since == PP) begin drop = 1; m_since = 0; end
         end
      end
      exp_q.push_back(mk(m_state, mv, ack, drop));
   endtask

   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {state_o, done, timeout, req_ack, move, ph_drop, step_cnt};
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL cycle_out t=%0t got st=%0d dn=%0b to=%0b ack=%0b mv=%b ph=%b sc=%0d exp st=%0d dn=%0b to=%0b ack=%0b mv=%b ph=%b sc=%0d",
                        $time, a.st, a.dn, a.to, a.ack, a.mv, a.ph, a.sc, e.st, e.dn, e.to, e.ack, e.mv, e.ph, e.sc);
            end
         end
      end
   end

   initial begin
      do_reset();
      repeat (2) drive(1, 2'b11, 0, 0, 0);
      do_reset();
      repeat (3) drive(1, 2'b11, 0, 0, 0);
      repeat (2) drive(0, 2'b11, 0, 0, 0);
      drive(1, 2'b10, 1, 0, 0);
      repeat (4) drive(1, 2'b11, 0, 0, 0);
      drive(1, 2'b10, 1, 0, 0);
      drive(1, 2'b10, 1, 0, 0);
      repeat (5) drive(1, 2'b10, 0, 0, 0);
      drive(1, 2'b11, 1, 0, 0);
      do_reset();
      repeat (3) drive(1, 2'b11, 0, 0, 0);
      do_reset();
      drive(0, 2'b00, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive(1, 2'b11, 0, 0, 0);
      do_reset();
      drive(0, 2'b00, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive(1, 2'b11, 0, 0, i == 2 ? 2'b01 : 2'b00);
      do_reset();
      drive(0, 2'b00, 0, 0, 0);
      repeat (LIM + 3) drive(1, 2'b11, 0, 0, 0);
      repeat (2) drive(1, 2'b11, 1, 1, 0);
      do_reset();
      drive(0, 2'b00, 0, 0, 0);
      drive(1, 2'b11, 1, 1, 0);
      repeat (4) drive(1, 2'b11, 1, 0, 0);
      repeat (3) drive(1, 2'b01, 0, 0, 0);
      for (int s = 0; s < 30; s++) begin
         do_reset();
         for (int c = 0; c < 40; c++)
            drive($urandom_range(3) != 0, 2'($urandom), $urandom_range(11) == 0, $urandom_range(59) == 0,
                  $urandom_range(3) == 0 ? 2'($urandom_range(3, 1)) : 2'b00);
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ant_nav_supervisor.md
Name: ant_nav_supervisor

Overview:
- Sequences the ant's move bus between the wall-follower decision logic and the ant body.
- Passes follower move requests through in normal running.
- On `hit`, takes over with a fixed recovery routine; on `escape`, halts permanently.
- Also enforces a step-budget watchdog and schedules pheromone drops.

Parameters:
- MV_HALT, 2'b00, encoding of halt move
- MV_RIGHT, 2'b01, encoding of turn-right move
- MV_LEFT, 2'b10, encoding of turn-left move
- MV_FWD, 2'b11, encoding of forward move
- PH_WIDTH, 2, pheromone bus width
- RECOVER_TURNS, 2, number of consecutive right turns issued after a hit (≥1)
- PH_PERIOD, 4, forward moves between pheromone drops (≥1)
- STEP_LIMIT, 1000, non-halt moves allowed before watchdog timeout
- STEP_W, 10, width of step counter (2^STEP_W−1 ≥ STEP_LIMIT)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  follower presents a move request this cycle
- req_move  input  2  follower requested move
- req_ack  output  1  registered; follower request accepted (one pulse per accepted request)
- hit  input  1  collision detected
- escape  input  1  maze exit reached
- ph_detected  input  PH_WIDTH  pheromone sensed under ant
- ph_drop  output  PH_WIDTH  registered pheromone deposit command
- move  output  2  registered move command to ant body
- step_cnt  output  STEP_W  non-halt moves issued since reset, saturating
- state_o  output  3  current state: IDLE=0, RUN=1, RECOVER=2, DONE=3, TIMEOUT=4
- done  output  1  sticky; escape achieved
- timeout  output  1  sticky; step budget exhausted

Behaviour:
Decided interface:
- One clock `clk`; reset `rst_n` is asynchronous, active-low.
- While `rst_n`=0: state=IDLE, move=MV_HALT, ph_drop=0, req_ack=0, step_cnt=0, done=0, timeout=0. Recovery counter and forward counter are also 0.
- Reset mid-operation aborts any recovery immediately.

Timing:
- All outputs are registered.
- Inputs sampled at edge N determine move/req_ack/ph_drop visible after edge N (one-cycle latency).

States:
- IDLE: move=HALT for one cycle after reset release, then RUN. Inputs are ignored.
- RUN, priority escape > hit > watchdog > request:
  - escape=1 → DONE, move=HALT.
  - hit=1 → RECOVER, move=MV_RIGHT, rec_cnt=RECOVER_TURNS−1, req_ack=0.
  - step_cnt==STEP_LIMIT → TIMEOUT, move=HALT.
  - req_valid=1 → move=req_move, req_ack=1.
  - otherwise → move=HALT, req_ack=0.
- RECOVER (req_ack=0 throughout, follower requests dropped not queued):
  - escape → DONE.
  - hit again → rec_cnt reloads RECOVER_TURNS−1, move=RIGHT.
  - rec_cnt>0 → move=RIGHT, rec_cnt−1.
  - rec_cnt==0 → move=MV_FWD, then RUN.
  - Total after one hit: RECOVER_TURNS RIGHT cycles, then one FWD.
- DONE: move=HALT, done=1, ph_drop=0. Sticky until reset.
- TIMEOUT: move=HALT, timeout=1, ph_drop=0. Sticky until reset. The escape input is ignored.

Counters and pheromone:
- step_cnt increments on every issued move ≠ MV_HALT, in RUN or RECOVER, and saturates at 2^STEP_W−1.
- Watchdog check uses the current registered step_cnt.
- Pheromone: on each issued MV_FWD, if ph_detected≠0 then fwd_cnt←0 and ph_drop=0.
  - Else if fwd_cnt==PH_PERIOD−1: ph_drop=1 for one cycle and fwd_cnt←0.
  - Else fwd_cnt+1.
  - Non-forward moves leave fwd_cnt unchanged, ph_drop=0.
- Simultaneous hit+escape: escape wins.
- Simultaneous hit + req_valid: request dropped, req_ack=0.

Test Plan:
- Reset/IDLE: assert rst_n=0 mid-RECOVER, release → move=00, state_o=0 for 1 cycle, then state_o=1. done=timeout=step_cnt=0.
- Passthrough: RUN, req_valid=1, req_move=11 for 3 cycles → move=11 one cycle later each, req_ack=1 each cycle, step_cnt=3. req_valid=0 → move=00, step_cnt holds.
- Hit recovery: hit pulse 1 cycle in RUN with req_valid=1 → move sequence 01,01,11, then follower passthrough, req_ack=0 for those 3 cycles. A second hit during the first 01 → sequence extends to 01,01,01,11.
- Escape priority: hit=1 and escape=1 same cycle → state_o=3, done=1, move=00 forever. Later req_valid/hit have no effect until reset.
- Pheromone: ph_detected=0, 8 consecutive forward requests → ph_drop=1 after the 4th and 8th forward only. ph_detected=2'b01 during the 3rd → counter clears, next drop after 7th.
- Watchdog: STEP_LIMIT=5, continuous forward requests → 5 moves of 11, then move=00, timeout=1, state_o=4, step_cnt=5. A later escape=1 leaves done=0.
